// File: rtl/ifetch_pkg.sv
// Shared definitions for the prefetching instruction fetch stage.
// Holds the default geometry, the default fetch entry layout and the
// pointer-width helper used by the FIFO and the fetch top.
package ifetch_pkg;

  localparam int AW_DEF       = 8;
  localparam int IW_DEF       = 20;
  localparam int DEPTH_DEF    = 4;
  localparam int RESET_PC_DEF = 0;

  localparam int PTR_W = $clog2(DEPTH_DEF);

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [IW_DEF-1:0] ins;
    logic [AW_DEF-1:0] pc;
  } fetch_entry_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO: synchronous, power-of-two depth, fall-through head.
// Flush clears occupancy and pointers and takes priority over push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int W     = IW_DEF + AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [PW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset and flush clear everything.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; written only when the push is actually accepted.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Prefetching instruction fetch stage. Owns the PC, issues reads to a
// 1-cycle-latency ROM only when the FIFO is guaranteed room for the reply,
// and flushes on redirect. An epoch bit tags each read so replies issued
// before a redirect can never land in the FIFO.
// Optional build macro: IFETCH_STATS_EN adds saturating fetch/flush counters.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pc_mux_sel,
  input  logic [AW-1:0] jmp_loc,
  output logic [AW-1:0] imem_addr,
  output logic          imem_en,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] ins,
  output logic [AW-1:0] ins_pc,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [AW-1:0] fetch_pc
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]   stat_fetched,
  output logic [31:0]   stat_flushed
`endif
);

  localparam int PW = ptr_width(DEPTH);

  typedef struct packed {
    logic [IW-1:0] ins;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0] pc;
  logic          inflight;
  logic          epoch;
  logic          tag_epoch;
  logic [AW-1:0] tag_addr;
  logic          pop;
  logic          issue;
  logic          credit_ok;
  logic          resp_ok;
  entry_t        wentry;
  entry_t        head;
  logic [PW:0]   count;
  logic          full;
  logic          empty;

  assign pop       = ins_valid & ins_ready;
  assign imem_addr = pc_mux_sel ? jmp_loc : pc;
  assign issue     = reset & credit_ok;
  assign imem_en   = issue;
  assign resp_ok   = inflight & (tag_epoch == epoch);
  assign wentry    = '{ins: imem_rdata, pc: tag_addr};

  assign ins_valid = ~empty;
  assign ins       = ins_valid ? head.ins : '0;
  assign ins_pc    = ins_valid ? head.pc  : '0;
  assign fetch_pc  = pc;

  // Credit check: room must exist after this cycle's pop for both the
  // outstanding reply and the one we are about to request. A redirect
  // empties everything, so it always has room.
  always_comb begin
    credit_ok = 1'b0;
    if (pc_mux_sel)
      credit_ok = 1'b1;
    else if (inflight)
      credit_ok = (int'(count) - int'(pop) + 1) < DEPTH;
    else
      credit_ok = ~full | pop;
  end

  // PC, outstanding-read tag and epoch tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= RESET_PC;
      inflight  <= 1'b0;
      epoch     <= 1'b0;
      tag_epoch <= 1'b0;
      tag_addr  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc        <= imem_addr + 1'b1;
        tag_addr  <= imem_addr;
        tag_epoch <= epoch ^ pc_mux_sel;
      end else if (pc_mux_sel) begin
        pc <= jmp_loc;
      end
      if (pc_mux_sel) epoch <= ~epoch;
    end
  end

  ifetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (pc_mux_sel),
    .push  (resp_ok),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef IFETCH_STATS_EN
  logic        fifo_write;
  logic [32:0] fetched_sum;
  logic [32:0] flushed_sum;

  assign fifo_write  = resp_ok & ~pc_mux_sel;
  assign fetched_sum = {1'b0, stat_fetched} + 33'd1;
  assign flushed_sum = {1'b0, stat_flushed} + 33'(count) + 33'(resp_ok);

  // Saturating counters of accepted fetches and of work discarded by redirects.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (fifo_write)
        stat_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      if (pc_mux_sel)
        stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: a cycle-by-cycle vector table covering
// reset, free run, backpressure, redirects (including full FIFO + pop) and
// PC wrap, followed by a hand-written backpressure/release sequence.
module tb_ifetch_prefetch;

  logic        clk;
  logic        reset;
  logic        pc_mux_sel;
  logic [7:0]  jmp_loc;
  logic [7:0]  imem_addr;
  logic        imem_en;
  logic [19:0] imem_rdata;
  logic [19:0] ins;
  logic [7:0]  ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  fetch_pc;
`ifdef IFETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  int checks = 0;
  int errors = 0;

  ifetch_prefetch dut (
    .clk        (clk),
    .reset      (reset),
    .pc_mux_sel (pc_mux_sel),
    .jmp_loc    (jmp_loc),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .fetch_pc   (fetch_pc)
`ifdef IFETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_flushed (stat_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word at address a is 0x100 + a, one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 20'h100 + {12'h000, imem_addr};
  end

  typedef struct {
    logic       r;
    logic       s;
    logic [7:0] j;
    logic       y;
    logic       v;
    logic [7:0] p;
    logic       e;
    logic [7:0] a;
    logic [7:0] f;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic s, logic [7:0] j, logic y,
                              logic v, logic [7:0] p, logic e, logic [7:0] a,
                              logic [7:0] f);
    vec_t t;
    t.r = r; t.s = s; t.j = j; t.y = y;
    t.v = v; t.p = p; t.e = e; t.a = a; t.f = f;
    return t;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    logic [19:0] exp_ins;
    int          en_cnt;
    int          got;
    int          budget;
    logic [7:0]  exp_pc;

    //                r  s  jmp    rdy  | val pc    en  addr   fpc
    vecs[0]  = mk(0, 0, 8'h00, 1,   0, 8'h00, 0, 8'h00, 8'h00);
    vecs[1]  = mk(0, 0, 8'h00, 1,   0, 8'h00, 0, 8'h00, 8'h00);
    vecs[2]  = mk(1, 0, 8'h00, 1,   0, 8'h00, 1, 8'h00, 8'h00);
    vecs[3]  = mk(1, 0, 8'h00, 1,   0, 8'h00, 1, 8'h01, 8'h01);
    vecs[4]  = mk(1, 0, 8'h00, 1,   1, 8'h00, 1, 8'h02, 8'h02);
    vecs[5]  = mk(1, 0, 8'h00, 0,   1, 8'h01, 1, 8'h03, 8'h03);
    vecs[6]  = mk(1, 0, 8'h00, 0,   1, 8'h01, 1, 8'h04, 8'h04);
    vecs[7]  = mk(1, 0, 8'h00, 0,   1, 8'h01, 0, 8'h05, 8'h05);
    vecs[8]  = mk(1, 0, 8'h00, 0,   1, 8'h01, 0, 8'h05, 8'h05);
    vecs[9]  = mk(1, 0, 8'h00, 0,   1, 8'h01, 0, 8'h05, 8'h05);
    vecs[10] = mk(1, 0, 8'h00, 1,   1, 8'h01, 1, 8'h05, 8'h05);
    vecs[11] = mk(1, 0, 8'h00, 1,   1, 8'h02, 1, 8'h06, 8'h06);
    vecs[12] = mk(1, 0, 8'h00, 1,   1, 8'h03, 1, 8'h07, 8'h07);
    vecs[13] = mk(1, 1, 8'h40, 1,   1, 8'h04, 1, 8'h40, 8'h08);
    vecs[14] = mk(1, 0, 8'h00, 1,   0, 8'h00, 1, 8'h41, 8'h41);
    vecs[15] = mk(1, 0, 8'h00, 1,   1, 8'h40, 1, 8'h42, 8'h42);
    vecs[16] = mk(1, 0, 8'h00, 1,   1, 8'h41, 1, 8'h43, 8'h43);
    vecs[17] = mk(1, 0, 8'h00, 0,   1, 8'h42, 1, 8'h44, 8'h44);
    vecs[18] = mk(1, 0, 8'h00, 0,   1, 8'h42, 1, 8'h45, 8'h45);
    vecs[19] = mk(1, 0, 8'h00, 0,   1, 8'h42, 0, 8'h46, 8'h46);
    vecs[20] = mk(1, 1, 8'hFE, 1,   1, 8'h42, 1, 8'hFE, 8'h46);
    vecs[21] = mk(1, 0, 8'h00, 1,   0, 8'h00, 1, 8'hFF, 8'hFF);
    vecs[22] = mk(1, 0, 8'h00, 1,   1, 8'hFE, 1, 8'h00, 8'h00);
    vecs[23] = mk(1, 0, 8'h00, 1,   1, 8'hFF, 1, 8'h01, 8'h01);
    vecs[24] = mk(1, 0, 8'h00, 1,   1, 8'h00, 1, 8'h02, 8'h02);
    vecs[25] = mk(1, 0, 8'h00, 0,   1, 8'h01, 1, 8'h03, 8'h03);
    vecs[26] = mk(1, 0, 8'h00, 0,   1, 8'h01, 1, 8'h04, 8'h04);
    vecs[27] = mk(0, 0, 8'h00, 0,   1, 8'h01, 0, 8'h05, 8'h05);
    vecs[28] = mk(1, 0, 8'h00, 1,   0, 8'h00, 1, 8'h00, 8'h00);
    vecs[29] = mk(1, 0, 8'h00, 1,   0, 8'h00, 1, 8'h01, 8'h01);
    vecs[30] = mk(1, 0, 8'h00, 1,   1, 8'h00, 1, 8'h02, 8'h02);
    vecs[31] = mk(1, 0, 8'h00, 1,   1, 8'h01, 1, 8'h03, 8'h03);

    reset      = 1'b0;
    pc_mux_sel = 1'b0;
    jmp_loc    = 8'h00;
    ins_ready  = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      reset      = vecs[i].r;
      pc_mux_sel = vecs[i].s;
      jmp_loc    = vecs[i].j;
      ins_ready  = vecs[i].y;
      #3;
      exp_ins = vecs[i].v ? (20'h100 + {12'h000, vecs[i].p}) : 20'h0;
      chk("ins_valid", i, 32'(ins_valid), 32'(vecs[i].v));
      chk("ins_pc",    i, 32'(ins_pc),    32'(vecs[i].p));
      chk("ins",       i, 32'(ins),       32'(exp_ins));
      chk("imem_en",   i, 32'(imem_en),   32'(vecs[i].e));
      chk("imem_addr", i, 32'(imem_addr), 32'(vecs[i].a));
      chk("fetch_pc",  i, 32'(fetch_pc),  32'(vecs[i].f));
`ifdef IFETCH_STATS_EN
      if (i == 28) begin
        chk("stat_fetched_rst", i, stat_fetched, 32'd0);
        chk("stat_flushed_rst", i, stat_flushed, 32'd0);
      end
`endif
      @(posedge clk);
      #1;
    end

    // Hold off the consumer: head must stay put, fetch stops after two reads.
    pc_mux_sel = 1'b0;
    reset      = 1'b1;
    ins_ready  = 1'b0;
    en_cnt     = 0;
    for (int k = 0; k < 6; k++) begin
      #3;
      chk("bp_ins_pc", 100 + k, 32'(ins_pc), 32'h02);
      chk("bp_ins",    100 + k, 32'(ins),    32'h102);
      if (imem_en) en_cnt++;
      @(posedge clk);
      #1;
    end
    chk("bp_issue_count", 106, 32'(en_cnt), 32'd2);
    chk("bp_fetch_pc",    106, 32'(fetch_pc), 32'h06);

    // Release: accepted addresses must be consecutive from the held head.
    ins_ready = 1'b1;
    exp_pc    = 8'h02;
    got       = 0;
    budget    = 40;
    while (got < 10 && budget > 0) begin
      #3;
      if (ins_valid) begin
        chk("rel_ins_pc", 200 + got, 32'(ins_pc), 32'(exp_pc));
        chk("rel_ins",    200 + got, 32'(ins), 32'(20'h100 + {12'h000, exp_pc}));
        exp_pc = exp_pc + 8'h01;
        got++;
      end
      budget--;
      @(posedge clk);
      #1;
    end
    chk("rel_accept_count", 300, 32'(got), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
